// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Optional single-cycle multiply when FAST_MUL_EN is defined; divide is always iterative.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             startE,
  input  logic [2:0]       MulDivOpE,
  input  logic [WIDTH-1:0] rs1_dataE,
  input  logic [WIDTH-1:0] rs2_dataE,
  input  logic [4:0]       rdE,
  output logic             busyE,
  output logic             doneE,
  output logic [WIDTH-1:0] resultE,
  output logic [4:0]       rd_outE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [4:0]         r_rd;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic               r_special;
  logic [WIDTH-1:0]   r_spec_res;

  // Capture-time decode: operand signedness, magnitudes, result sign, special cases
  logic             w_a_signed, w_b_signed, w_sa, w_sb, w_neg, w_div0, w_ovf;
  logic [WIDTH-1:0] w_amag, w_bmag, w_spec_res;

  assign w_a_signed = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b010) ||
                      (MulDivOpE == 3'b100) || (MulDivOpE == 3'b110);
  assign w_b_signed = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b100) ||
                      (MulDivOpE == 3'b110);
  assign w_sa   = w_a_signed & rs1_dataE[WIDTH-1];
  assign w_sb   = w_b_signed & rs2_dataE[WIDTH-1];
  assign w_amag = w_sa ? -rs1_dataE : rs1_dataE;
  assign w_bmag = w_sb ? -rs2_dataE : rs2_dataE;
  // Remainder takes the dividend's sign; everything else the XOR of both
  assign w_neg  = (MulDivOpE[2] & MulDivOpE[1]) ? w_sa : (w_sa ^ w_sb);
  assign w_div0 = MulDivOpE[2] & (rs2_dataE == '0);
  assign w_ovf  = MulDivOpE[2] & ~MulDivOpE[0] &
                  (rs1_dataE == {1'b1, {(WIDTH-1){1'b0}}}) & (rs2_dataE == '1);

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = MulDivOpE[1] ? rs1_dataE : '1;
    else if (w_ovf)
      w_spec_res = MulDivOpE[1] ? '0 : rs1_dataE;
  end

  // Multiply datapath
  logic [2*WIDTH-1:0] w_prod_fin, w_prod_sgn;
  logic [WIDTH-1:0]   w_mul_res;

`ifdef FAST_MUL_EN
  assign w_prod_fin = {{WIDTH{1'b0}}, r_opa} * {{WIDTH{1'b0}}, r_opb};
`else
  logic [WIDTH:0] w_sum;
  // Product register low half shifts out multiplier bits as the high half accumulates
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opa & {WIDTH{r_prod[0]}}};
  assign w_prod_fin = {w_sum, r_prod[WIDTH-1:1]};
`endif

  assign w_prod_sgn = r_neg ? -w_prod_fin : w_prod_fin;
  assign w_mul_res  = (r_op == 2'b00) ? w_prod_sgn[WIDTH-1:0] : w_prod_sgn[2*WIDTH-1:WIDTH];

  // Restoring divide step: dividend shifts out of r_prod low half, quotient shifts in
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_div_res;

  assign w_shift   = {r_rem, r_prod[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opb};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_prod[WIDTH-2:0], w_qbit};
  assign w_div_res = r_op[1] ? (r_neg ? -w_rem_nxt : w_rem_nxt)
                             : (r_neg ? -w_quo_nxt : w_quo_nxt);

  assign busyE = ((r_state == S_IDLE) & startE) | (r_state == S_MUL) | (r_state == S_DIV);
  assign doneE = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_neg      <= 1'b0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      resultE    <= '0;
      rd_outE    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (startE) begin
            r_op       <= MulDivOpE[1:0];
            r_rd       <= rdE;
            r_opa      <= w_amag;
            r_opb      <= w_bmag;
            r_neg      <= w_neg;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_special  <= w_div0 | w_ovf;
            r_spec_res <= w_spec_res;
            r_prod     <= {{WIDTH{1'b0}}, MulDivOpE[2] ? w_amag : w_bmag};
            r_state    <= MulDivOpE[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
`ifdef FAST_MUL_EN
          resultE <= w_mul_res;
          rd_outE <= r_rd;
          r_state <= S_DONE;
`else
          r_prod <= w_prod_fin;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            resultE <= w_mul_res;
            rd_outE <= r_rd;
            r_state <= S_DONE;
          end
`endif
        end
        S_DIV: begin
          if (r_special) begin
            resultE <= r_spec_res;
            rd_outE <= r_rd;
            r_state <= S_DONE;
          end else begin
            r_prod[WIDTH-1:0] <= w_quo_nxt;
            r_rem             <= w_rem_nxt;
            r_cnt             <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              resultE <= w_div_res;
              rd_outE <= r_rd;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
